pipeline_if_id_reg: RTL and testbench
=====================================

Name: pipeline_if_id_reg

Overview:
- IF/ID pipeline register that directly consumes the program counter and the instruction fetched at it.
- Produces IF_ID_PC_4, IF_ID_Instruct and IF_ID_Valid for the decode stage.
- Handles stall (hold), flush (bubble) and external interrupt insertion.
- Its IntReq pulse tells control to drive PCSrc=3'b100, which redirects the PC to ILLOP at 32'h8000_0004.

Parameters:
- DATA_W, 32, width of PC and instruction paths.
- NOP, 32'h0000_0000, instruction word inserted for bubbles.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- PC  input  DATA_W  current fetch address; bit 31 is the kernel/supervisor bit.
- Instruct  input  DATA_W  instruction memory read data for PC.
- IF_ID_Write  input  1  1 = register may load; 0 = stall and hold.
- IF_ID_Flush  input  1  1 = load bubble; used for branch/jump taken.
- IRQ  input  1  external interrupt request, level; rising edge requests service.
- IntReq  output  1  combinational one-cycle accept pulse to control.
- IF_ID_PC_4  output  DATA_W  registered return/link address.
- IF_ID_Instruct  output  DATA_W  registered instruction.
- IF_ID_Valid  output  1  0 = bubble.
- IrqDropCnt  output  8  dropped-request counter; exists only with the optional feature.

Behaviour:
- Reset (async, active-high): IF_ID_PC_4=0, IF_ID_Instruct=NOP, IF_ID_Valid=0, irq_q=0, FSM=IDLE. IntReq is 0 while reset is high.
- Reset asserted mid-operation discards any pending interrupt.
- PC_4 = {PC[31], PC[30:0]+31'd4}.
  - Bit 31 is preserved; the low 31 bits wrap modulo 2^31, so 32'h7FFF_FFFC gives 32'h0000_0000 and 32'hFFFF_FFFC gives 32'h8000_0000.
- Register update priority per rising edge, highest first:
  - 1. IF_ID_Flush=1: Instruct<=NOP, Valid<=0, PC_4<=PC_4 (computed). Flush overrides stall.
  - 2. IF_ID_Write=0: hold all three registers.
  - 3. IntReq=1: Instruct<=NOP, Valid<=0, PC_4<=PC. This is the address of the squashed instruction, so the handler returns to it.
  - 4. Otherwise: Instruct<=Instruct, Valid<=1, PC_4<=PC_4.
- Latency: exactly one cycle from fetch to the IF/ID outputs.
- Edge detect: irq_q<=IRQ every cycle; irq_rise = IRQ & ~irq_q.
- FSM states: IDLE, PENDING, SERVICE.
  - IDLE: on irq_rise, go to PENDING.
  - PENDING: accept = ~PC[31] & IF_ID_Write & ~IF_ID_Flush.
    - IntReq = accept; this is the only Mealy output.
    - On accept, go to SERVICE; otherwise stay in PENDING.
    - Kernel mode (PC[31]=1), stall or flush defer acceptance indefinitely.
  - SERVICE: stay until PC[31]=1 is sampled (handler entered), then go to IDLE.
- IntReq is never asserted in IDLE or SERVICE and never for more than one consecutive cycle per request.
- An irq_rise while in PENDING or SERVICE is dropped: no queuing and no state change.
- An irq_rise in the same cycle the FSM returns SERVICE->IDLE is also dropped.

Optional Feature:
- Macro IF_ID_IRQ_DROP_CNT_EN.
- With the macro defined:
  - IrqDropCnt port exists.
  - It increments on each dropped irq_rise, saturates at 8'hFF, and resets to 0.
- Without the macro:
  - The port and the counter are absent.
  - Drops are silent.

Test Plan:
- Reset then normal fetch: PC=32'h0000_0010, Instruct=32'h2008_0005, Write=1 -> next edge IF_ID_PC_4=32'h0000_0014, IF_ID_Instruct=32'h2008_0005, IF_ID_Valid=1.
- Stall hold: Write=0 for 3 cycles while PC and Instruct change -> outputs unchanged. Flush+stall in the same cycle -> IF_ID_Instruct=NOP, IF_ID_Valid=0.
- Wrap: PC=32'hFFFF_FFFC -> IF_ID_PC_4=32'h8000_0000. PC=32'h7FFF_FFFC -> IF_ID_PC_4=32'h0000_0000.
- Interrupt user mode: IRQ rises, PC=32'h0000_0040, Write=1 -> IntReq=1 in the PENDING cycle. Next edge IF_ID_PC_4=32'h0000_0040, IF_ID_Valid=0. PC=32'h8000_0004 sampled -> FSM returns to IDLE.
- Interrupt deferred: IRQ rises while PC=32'h8000_0100 for 5 cycles -> IntReq=0 throughout. PC=32'h0000_0200 with Write=1 -> IntReq=1 for exactly one cycle.
- Drops: with IF_ID_IRQ_DROP_CNT_EN, pulse IRQ 3 times during PENDING/SERVICE -> IrqDropCnt=3. Mid-PENDING reset -> IntReq=0, FSM=IDLE, IrqDropCnt=0.

Source files
------------

// File: rtl/pipeline_if_id_reg.sv
// IF/ID pipeline register with stall, flush and external interrupt insertion.
// Optional dropped-IRQ counter: define IF_ID_IRQ_DROP_CNT_EN.
module pipeline_if_id_reg #(
  parameter int                DATA_W = 32,
  parameter logic [DATA_W-1:0] NOP    = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] PC,
  input  logic [DATA_W-1:0] Instruct,
  input  logic              IF_ID_Write,
  input  logic              IF_ID_Flush,
  input  logic              IRQ,
  output logic              IntReq,
  output logic [DATA_W-1:0] IF_ID_PC_4,
  output logic [DATA_W-1:0] IF_ID_Instruct,
`ifdef IF_ID_IRQ_DROP_CNT_EN
  output logic              IF_ID_Valid,
  output logic [7:0]        IrqDropCnt
`else
  output logic              IF_ID_Valid
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] pc_4;
    logic [DATA_W-1:0] instr;
    logic              valid;
  } if_id_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SERVICE = 2'd2
  } irq_st_t;

  if_id_t            q;
  if_id_t            d;
  irq_st_t           state;
  irq_st_t           state_nx;
  logic              irq_q;
  logic              irq_rise;
  logic              kernel;
  logic              accept;
  logic [DATA_W-1:0] pc_4;

  logic do_flush;
  logic do_hold;
  logic do_int;
  logic do_load;

  // Kernel bit rides through; only the low bits wrap.
  assign pc_4 = {PC[DATA_W-1],
                 PC[DATA_W-2:0] + (DATA_W-1)'(4)};

  assign kernel   = PC[DATA_W-1];
  assign irq_rise = IRQ & ~irq_q;
  assign accept   = ~kernel & IF_ID_Write
                  & ~IF_ID_Flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= IRQ;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (irq_rise) state_nx = PENDING;
      PENDING: if (accept)   state_nx = SERVICE;
      SERVICE: if (kernel)   state_nx = IDLE;
      default:               state_nx = IDLE;
    endcase
  end

  always_comb begin
    IntReq = 1'b0;
    if (state == PENDING && !reset)
      IntReq = accept;
  end

  // One-hot decode of the update priority.
  assign do_flush = IF_ID_Flush;
  assign do_hold  = ~IF_ID_Flush & ~IF_ID_Write;
  assign do_int   = ~IF_ID_Flush & IF_ID_Write
                  & IntReq;
  assign do_load  = ~IF_ID_Flush & IF_ID_Write
                  & ~IntReq;

  always_comb begin
    d = q;
    unique case (1'b1)
      do_flush: begin
        d.pc_4  = pc_4;
        d.instr = NOP;
        d.valid = 1'b0;
      end
      do_hold: d = q;
      do_int: begin
        d.pc_4  = PC;
        d.instr = NOP;
        d.valid = 1'b0;
      end
      do_load: begin
        d.pc_4  = pc_4;
        d.instr = Instruct;
        d.valid = 1'b1;
      end
      default: d = q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q.pc_4  <= '0;
      q.instr <= NOP;
      q.valid <= 1'b0;
    end else begin
      q <= d;
    end
  end

  assign IF_ID_PC_4     = q.pc_4;
  assign IF_ID_Instruct = q.instr;
  assign IF_ID_Valid    = q.valid;

`ifdef IF_ID_IRQ_DROP_CNT_EN
  logic       drop;
  logic [7:0] drop_cnt;

  // Covers the SERVICE->IDLE edge too.
  assign drop = irq_rise & (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      drop_cnt <= 8'h00;
    else if (drop && drop_cnt != 8'hFF)
      drop_cnt <= drop_cnt + 8'h01;
  end

  assign IrqDropCnt = drop_cnt;
`endif

endmodule

// File: tb/tb_pipeline_if_id_reg.sv
// Directed bench for pipeline_if_id_reg.
// Drop counter checks compile in with IF_ID_IRQ_DROP_CNT_EN.
module tb_pipeline_if_id_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC;
  logic [31:0] Instruct;
  logic        IF_ID_Write;
  logic        IF_ID_Flush;
  logic        IRQ;
  logic        IntReq;
  logic [31:0] IF_ID_PC_4;
  logic [31:0] IF_ID_Instruct;
  logic        IF_ID_Valid;
`ifdef IF_ID_IRQ_DROP_CNT_EN
  logic [7:0]  IrqDropCnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_if_id_reg dut (
    .clk           (clk),
    .reset         (reset),
    .PC            (PC),
    .Instruct      (Instruct),
    .IF_ID_Write   (IF_ID_Write),
    .IF_ID_Flush   (IF_ID_Flush),
    .IRQ           (IRQ),
    .IntReq        (IntReq),
    .IF_ID_PC_4    (IF_ID_PC_4),
    .IF_ID_Instruct(IF_ID_Instruct),
`ifdef IF_ID_IRQ_DROP_CNT_EN
    .IF_ID_Valid   (IF_ID_Valid),
    .IrqDropCnt    (IrqDropCnt)
`else
    .IF_ID_Valid   (IF_ID_Valid)
`endif
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic regs(input string tag,
                      input logic [31:0] pc4,
                      input logic [31:0] ins,
                      input logic v);
    check({tag, ".pc4"}, IF_ID_PC_4, pc4);
    check({tag, ".ins"}, IF_ID_Instruct, ins);
    check({tag, ".vld"}, {31'd0, IF_ID_Valid},
          {31'd0, v});
  endtask

  initial begin
    reset       = 1'b1;
    PC          = 32'h0;
    Instruct    = 32'h0;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    IRQ         = 1'b0;
    #2;
    regs("rst", 32'h0, 32'h0, 1'b0);
    check("rst.intreq", {31'd0, IntReq}, 32'd0);
    tick();
    tick();
    reset = 1'b0;

    // Normal fetch
    PC       = 32'h0000_0010;
    Instruct = 32'h2008_0005;
    tick();
    regs("fetch", 32'h0000_0014, 32'h2008_0005, 1'b1);

    // Stall holds for 3 cycles
    IF_ID_Write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      PC       = 32'h0000_0100 + 32'(i * 4);
      Instruct = 32'hDEAD_0000 + 32'(i);
      tick();
      regs("stall", 32'h0000_0014, 32'h2008_0005, 1'b1);
    end

    // Flush beats stall
    IF_ID_Flush = 1'b1;
    PC          = 32'h0000_0100;
    Instruct    = 32'hAAAA_AAAA;
    tick();
    regs("flush", 32'h0000_0104, 32'h0, 1'b0);

    // Wrap cases
    IF_ID_Flush = 1'b0;
    IF_ID_Write = 1'b1;
    PC          = 32'hFFFF_FFFC;
    Instruct    = 32'h1111_1111;
    tick();
    regs("wrapk", 32'h8000_0000, 32'h1111_1111, 1'b1);
    PC = 32'h7FFF_FFFC;
    tick();
    check("wrapu.pc4", IF_ID_PC_4, 32'h0000_0000);

    // Interrupt in user mode
    PC       = 32'h0000_0040;
    Instruct = 32'h2222_2222;
    IRQ      = 1'b1;
    #1;
    check("idle.intreq", {31'd0, IntReq}, 32'd0);
    tick();
    regs("pend", 32'h0000_0044, 32'h2222_2222, 1'b1);
    check("pend.intreq", {31'd0, IntReq}, 32'd1);
    tick();
    regs("irq", 32'h0000_0040, 32'h0, 1'b0);
    check("svc.intreq", {31'd0, IntReq}, 32'd0);
    PC       = 32'h8000_0004;
    Instruct = 32'h3333_3333;
    IRQ      = 1'b0;
    tick();
    regs("hdlr", 32'h8000_0008, 32'h3333_3333, 1'b1);

    // Deferred while in kernel mode
    PC  = 32'h8000_0100;
    IRQ = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("defer.intreq", {31'd0, IntReq}, 32'd0);
      tick();
    end
    PC = 32'h0000_0200;
    #1;
    check("accept.intreq", {31'd0, IntReq}, 32'd1);
    tick();
    check("once.intreq", {31'd0, IntReq}, 32'd0);
    regs("acc", 32'h0000_0200, 32'h0, 1'b0);
    tick();
    check("svc2.intreq", {31'd0, IntReq}, 32'd0);
    PC  = 32'h8000_0004;
    IRQ = 1'b0;
    tick();

    // Drops during PENDING and SERVICE
    PC  = 32'h8000_0100;
    IRQ = 1'b1;
    tick();
    IRQ = 1'b0;
    tick();
    IRQ = 1'b1;
    tick();
    IRQ = 1'b0;
    tick();
    IRQ = 1'b1;
    tick();
    IRQ         = 1'b0;
    PC          = 32'h0000_0300;
    IF_ID_Write = 1'b0;
    #1;
    check("stall.intreq", {31'd0, IntReq}, 32'd0);
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b1;
    #1;
    check("flush.intreq", {31'd0, IntReq}, 32'd0);
    IF_ID_Flush = 1'b0;
    #1;
    check("drop.intreq", {31'd0, IntReq}, 32'd1);
    tick();
    IRQ = 1'b1;
    tick();
    IRQ = 1'b0;
`ifdef IF_ID_IRQ_DROP_CNT_EN
    check("dropcnt", {24'd0, IrqDropCnt}, 32'd3);
`endif
    PC = 32'h8000_0004;
    tick();

    // Reset while PENDING
    PC  = 32'h8000_0100;
    IRQ = 1'b1;
    tick();
    PC = 32'h0000_0400;
    #1;
    check("pend3.intreq", {31'd0, IntReq}, 32'd1);
    reset = 1'b1;
    IRQ   = 1'b0;
    #1;
    check("mrst.intreq", {31'd0, IntReq}, 32'd0);
    regs("mrst", 32'h0, 32'h0, 1'b0);
`ifdef IF_ID_IRQ_DROP_CNT_EN
    check("mrst.cnt", {24'd0, IrqDropCnt}, 32'd0);
`endif
    tick();
    reset = 1'b0;
    #1;
    check("post.intreq", {31'd0, IntReq}, 32'd0);
    tick();
    check("post2.intreq", {31'd0, IntReq}, 32'd0);
    regs("post", 32'h0000_0404, 32'h3333_3333, 1'b1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
